// File: rtl/rf_pkg.sv
// Shared register-file types: index/mask widths and the encoder FSM state.
package rf_pkg;
    localparam int RF_N = 8;
    localparam int RF_W = $clog2(RF_N);

    typedef logic [RF_W-1:0] rf_idx_t;
    typedef logic [RF_N-1:0] rf_mask_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of mask at or above start, with wrap.
module rr_pick
    import rf_pkg::*;
(
    input  rf_mask_t mask,
    input  rf_idx_t  start,
    output rf_idx_t  idx,
    output logic     found
);
    logic [2*RF_N-1:0] dbl;
    rf_mask_t          rot;
    rf_idx_t           off;

    // Rotate so that bit 'start' lands at position 0, then take the lowest set bit.
    always_comb begin
        dbl = {mask, mask} >> start;
        rot = dbl[RF_N-1:0];
        off = '0;
        for (int i = RF_N - 1; i >= 0; i--) begin
            if (rot[i]) off = rf_idx_t'(i);
        end
        idx   = start + off;
        found = |mask;
    end
endmodule

// File: rtl/rr_encoder8_3.sv
// Serializes an 8-bit request mask into 3-bit indices on a valid/ready stream, round-robin across loads.
module rr_encoder8_3
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     load,
    input  rf_mask_t req,
    input  logic     flush,
    output logic     load_ready,
    output logic     out_valid,
    output rf_idx_t  out_idx,
    input  logic     out_ready,
    output rf_mask_t pending,
    output logic     done
);
    enc_state_t state;
    rf_idx_t    ptr;

    rf_idx_t  load_idx;
    logic     load_found;
    rf_idx_t  adv_idx;
    logic     adv_found;
    rf_mask_t adv_mask;
    rf_idx_t  next_idx;

    assign next_idx = out_idx + rf_idx_t'(1);
    assign adv_mask = pending & ~(rf_mask_t'(1) << out_idx);

    rr_pick u_pick_load (
        .mask  (req),
        .start (ptr),
        .idx   (load_idx),
        .found (load_found)
    );

    rr_pick u_pick_adv (
        .mask  (adv_mask),
        .start (next_idx),
        .idx   (adv_idx),
        .found (adv_found)
    );

    assign load_ready = (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            // Flush wins over both load and a same-cycle handshake; ptr is untouched.
            if (flush) begin
                state     <= IDLE;
                pending   <= '0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (load && load_found) begin
                            pending   <= req;
                            out_idx   <= load_idx;
                            out_valid <= 1'b1;
                            state     <= EMIT;
                        end
                    end
                    EMIT: begin
                        if (out_ready) begin
                            ptr     <= next_idx;
                            pending <= adv_mask;
                            if (adv_found) begin
                                out_idx <= adv_idx;
                            end else begin
                                out_valid <= 1'b0;
                                done      <= 1'b1;
                                state     <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    a_valid_bit_pending: assert property (
        @(posedge clk) disable iff (!reset_n) out_valid |-> pending[out_idx]
    );
endmodule

// File: tb/tb_rr_encoder8_3.sv
// Directed-vector bench for rr_encoder8_3 with hand-computed expectations.
module tb_rr_encoder8_3;
    import rf_pkg::*;

    logic     clk = 1'b0;
    logic     reset_n;
    logic     load;
    rf_mask_t req;
    logic     flush;
    logic     load_ready;
    logic     out_valid;
    rf_idx_t  out_idx;
    logic     out_ready;
    rf_mask_t pending;
    logic     done;

    int checks = 0;
    int errors = 0;

    rr_encoder8_3 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .req        (req),
        .flush      (flush),
        .load_ready (load_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_ready  (out_ready),
        .pending    (pending),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full emitting-state output set in one call.
    task automatic chk_emit(input string tag, input int idx, input int pend);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".idx"}, 32'(out_idx), 32'(idx));
        chk({tag, ".pend"}, 32'(pending), 32'(pend));
        chk({tag, ".lrdy"}, 32'(load_ready), 32'd0);
    endtask

    task automatic chk_done(input string tag, input int exp_done);
        chk({tag, ".valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'(exp_done));
        chk({tag, ".pend"}, 32'(pending), 32'd0);
        chk({tag, ".lrdy"}, 32'(load_ready), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; req = '0; flush = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst.idx", 32'(out_idx), 32'd0);
        chk_done("rst", 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        step();

        // Basic drain: A4 -> 2, 5, 7, then done
        load = 1'b1; req = 8'hA4; out_ready = 1'b1;
        step(); load = 1'b0; req = '0;
        chk_emit("t1a", 2, 8'hA4);
        step(); chk_emit("t1b", 5, 8'hA0);
        step(); chk_emit("t1c", 7, 8'h80);
        step(); chk_done("t1d", 1);
        step(); chk("t1e.done", 32'(done), 32'd0);

        // FF, accept 0,1,2, flush with idx 3 presented; ptr stays 3
        load = 1'b1; req = 8'hFF;
        step(); load = 1'b0;
        chk_emit("t2a", 0, 8'hFF);
        step(); chk_emit("t2b", 1, 8'hFE);
        step(); chk_emit("t2c", 2, 8'hFC);
        step(); chk_emit("t2d", 3, 8'hF8);
        flush = 1'b1;
        step(); flush = 1'b0;
        chk_done("t2flush", 0);
        load = 1'b1; req = 8'h09;
        step(); load = 1'b0;
        chk_emit("t2e", 3, 8'h09);
        step(); chk_emit("t2f", 0, 8'h01);
        step(); chk_done("t2g", 1);

        // Backpressure: 10 held for 4 cycles, ptr=1 before
        out_ready = 1'b0; load = 1'b1; req = 8'h10;
        step(); load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_emit($sformatf("t3hold%0d", i), 4, 8'h10);
            if (i < 3) step();
        end
        out_ready = 1'b1;
        step(); chk_done("t3done", 1);
        step(); chk("t3.done2", 32'(done), 32'd0);

        // ptr=5: load 03 picks 0 by wrap; load in EMIT ignored
        out_ready = 1'b0; load = 1'b1; req = 8'h03;
        step(); chk_emit("t4a", 0, 8'h03);
        req = 8'hFF;
        step(); load = 1'b0;
        chk_emit("t4b", 0, 8'h03);
        out_ready = 1'b1;
        step(); chk_emit("t4c", 1, 8'h02);
        step(); chk_done("t4d", 1);
        load = 1'b1; req = 8'h00;
        step(); load = 1'b0;
        chk_done("t4zero", 0);
        step(); chk_done("t4zero2", 0);

        // ptr=2: F0 emits 4, accept, then async reset mid-cycle
        load = 1'b1; req = 8'hF0;
        step(); load = 1'b0;
        chk_emit("t5a", 4, 8'hF0);
        step(); chk_emit("t5b", 5, 8'hE0);
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("t5rst.idx", 32'(out_idx), 32'd0);
        chk_done("t5rst", 0);
        #1 reset_n = 1'b1;
        step();
        load = 1'b1; req = 8'h02; out_ready = 1'b1;
        step(); load = 1'b0;
        chk_emit("t5c", 1, 8'h02);
        step(); chk_done("t5d", 1);

        // flush + load in IDLE drops the load
        flush = 1'b1; load = 1'b1; req = 8'hFF;
        step(); flush = 1'b0; load = 1'b0;
        chk_done("t6a", 0);
        step(); chk_done("t6b", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_encoder8_3.md
# rr_encoder8_3

Sequential round-robin encoder that turns a one-hot/multi-hot 8-bit request mask into a stream of 3-bit register indices, one per accepted transfer. It sits in front of the register-file write/read address ports. Pending write-back or scrub requests are captured as a bit mask and serialized into binary register addresses on a valid/ready stream. It is the inverse of the register-file address decode path: mask in, index out, with fairness across loads.

## Interface
- N, 8, number of request lines; power of two, ≥ 2
- W, $clog2(N) = 3, index width
- clk  input  1  single clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- load  input  1  capture `req` when `load_ready` is high
- req  input  N  request mask
- flush  input  1  synchronous abort of the current mask
- load_ready  output  1  high in IDLE
- out_valid  output  1  `out_idx` is valid
- out_idx  output  W  encoded register index (registered)
- out_ready  input  1  consumer accepts `out_idx`
- pending  output  N  bits not yet emitted (registered)
- done  output  1  one-cycle pulse after the last index is accepted

## Operation
- FSM states: IDLE, EMIT.
- IDLE:
  - `load_ready`=1, `out_valid`=0.
  - `load` with `req`≠0: `pending`←`req`; `out_idx`←first set bit of `req` at or after `ptr`, scanning upward with wrap; go to EMIT.
  - `load` with `req`=0: no state change, no `done`.
- EMIT:
  - `out_valid`=1, `load_ready`=0. `load` is ignored.
  - A handshake is `out_valid`&&`out_ready`. On a handshake: clear bit `out_idx` in `pending`; `ptr`←(`out_idx`+1) mod N.
  - If bits remain after the clear, `out_idx`←first remaining set bit after the old `out_idx`, with wrap; stay in EMIT.
  - If no bits remain: go to IDLE and assert `done` for one cycle.
  - Without a handshake, `out_idx` and `pending` hold. Backpressure is lossless.
- `flush`:
  - Highest priority, any state: `pending`←0, `out_valid`←0, go to IDLE, no `done`.
  - `ptr` is kept at its value after the last handshake.
  - `flush` together with `load` in IDLE: the load is dropped.
- `ptr` persists across loads, which gives round-robin fairness between masks. Its wrap from N-1 to 0 is natural modulo arithmetic on W bits.
- Reset values: state=IDLE, `ptr`=0, `pending`=0, `out_idx`=0, `out_valid`=0, `done`=0, `load_ready`=1.
- Reset assertion mid-EMIT discards the mask immediately (asynchronously).
- Invariant: bit `out_idx` of `pending` is set whenever `out_valid`=1.

## Timing
- Load at edge k: `out_valid`=1 with the first index after edge k. Latency is 1 cycle.
- Throughput is 1 index per cycle while `out_ready`=1. A mask with P set bits drains in P cycles.
- Last handshake at edge m:
  - `done`=1 and `load_ready`=1 during cycle m+1.
  - A new `load` is accepted at edge m+1, giving one bubble cycle between masks.
- `out_idx`, `out_valid`, `pending`, `done` and `load_ready` are all registers or state decodes, with no combinational path from inputs.
- The scan is a combinational N-bit rotate plus priority pick feeding registers. This is a single-cycle path.

## Structure
- Shared package `rf_pkg`:
  - `RF_N`=8 and `RF_W`=3.
  - Typedefs `rf_idx_t` (logic [RF_W-1:0]) and `rf_mask_t` (logic [RF_N-1:0]).
  - FSM enum `enc_state_t` {IDLE, EMIT}.
- Sub-module `rr_pick`, combinational:
  - Inputs: `mask`, `start`.
  - Outputs: `idx` = first set bit ≥ `start` with wrap, and `found`.
  - Instanced once for the load path (start=`ptr`) and once for the advance path (start=`out_idx`+1, mask = `pending` with `out_idx` cleared). A single shared instance is acceptable if it is muxed.
- The top level holds the FSM, `ptr`, `pending` and the output registers.

## Test plan
- Reset, then load `req`=8'b1010_0100 with `out_ready`=1 → `out_idx` 2, 5, 7 on three consecutive cycles; `done` pulses the next cycle; `pending` reads 0xA4, 0xA0, 0x80, 0x00.
- Load 8'hFF and accept 0, 1, 2; `flush`; then load 8'b0000_1001 → emits 3 then 0 (round-robin wrap); `done` after 0.
- Load 8'b0001_0000 with `out_ready`=0 for 4 cycles → `out_idx`=4, `out_valid`=1 stable; raise `out_ready` → one handshake, then `done`.
- In EMIT, assert `load` with `req`=8'hFF → ignored; `pending` unchanged. In IDLE, load `req`=0 → stays IDLE, no `done`.
- Load 8'hF0, accept one index (4), then pulse `reset_n` low mid-cycle → outputs go to reset values at once (`out_valid`=0, `pending`=0); the next load of 8'h02 emits 1 (`ptr` is back at 0).
- `flush` and `load` in the same IDLE cycle → no capture; `out_valid` stays 0.
